// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults, pixel type and FSM states for the camera capture stage
package cam_pkg;
   localparam int H_ACTIVE_DEF = 320;
   localparam int V_ACTIVE_DEF = 240;
   localparam int ADDR_W_DEF   = 17;
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;
   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} cam_state_e;
endpackage

// File: rtl/cam_edge_det.sv
// cam_edge_det: registered rise/fall detector for an already-synchronous level
//   clk, rst_n : clock, async active-low reset
//   sig_i      : level to watch
//   rise_o     : high for the cycle where sig_i is 1 and was 0 the cycle before
//   fall_o     : high for the cycle where sig_i is 0 and was 1 the cycle before
module cam_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);
   logic prev_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= sig_i;
   assign rise_o = sig_i & ~prev_q;
   assign fall_o = ~sig_i & prev_q;
endmodule

// File: rtl/cam_capture.sv
// cam_capture: converts the 8-bit camera bus (two bytes per pixel) into RGB565 frame-buffer writes
//   cam_pclk, rst_n         : sole clock, async active-low reset
//   capture_en              : allow capture of the next frame, sampled at vsync fall
//   cam_vsync/href/data     : raw camera bus, registered once on entry
//   wr_en/wr_addr/wr_data   : frame-buffer write port, address = line_base + x
//   busy                    : high while a frame is being captured
//   frame_done, frame_ok    : end-of-frame pulse and its integrity verdict
//   test_en                 : only with CAM_CAPTURE_TESTPAT_EN defined; replaces pixel data
//                             with the low 16 address bits
module cam_capture
   import cam_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              cam_pclk,
   input  logic              rst_n,
   input  logic              capture_en,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
`ifdef CAM_CAPTURE_TESTPAT_EN
   input  logic              test_en,
`endif
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_ok
);
   localparam logic [ADDR_W-1:0] H = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] V = ADDR_W'(V_ACTIVE);

   cam_state_e        state_q, state_d;
   logic              vs_q, hr_q;
   logic [7:0]        d_q;
   logic              vs_rise, vs_fall, hr_fall, hr_rise_unused;
   logic [ADDR_W-1:0] x_q, x_d, y_q, y_d, base_q, base_d;
   logic              ph_q, ph_d, err_q, err_d;
   logic [7:0]        hi_q, hi_d;
   logic              wr_en_q, wr_en_d, done_q, done_d, ok_q, ok_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr;
   rgb565_t           wr_data_q, wr_data_d, pix;

   cam_edge_det u_vs (.clk(cam_pclk), .rst_n(rst_n), .sig_i(vs_q), .rise_o(vs_rise), .fall_o(vs_fall));
   cam_edge_det u_hr (.clk(cam_pclk), .rst_n(rst_n), .sig_i(hr_q), .rise_o(hr_rise_unused), .fall_o(hr_fall));

   assign addr = base_q + x_q;
`ifdef CAM_CAPTURE_TESTPAT_EN
   assign pix = test_en ? rgb565_t'(16'(addr)) : rgb565_t'({hi_q, d_q});
`else
   assign pix = rgb565_t'({hi_q, d_q});
`endif

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      base_d    = base_q;
      ph_d      = ph_q;
      hi_d      = hi_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      ok_d      = ok_q;
      case (state_q)
         IDLE:  if (vs_q) state_d = ARMED;
         ARMED: if (vs_fall && capture_en) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            base_d  = '0;
            ph_d    = 1'b0;
            err_d   = 1'b0;
         end
         ACTIVE: begin
            if (hr_q && !ph_q) begin
               hi_d = d_q;
               ph_d = 1'b1;
            end else if (hr_q) begin
               ph_d = 1'b0;
               if (x_q < H && y_q < V) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr;
                  wr_data_d = pix;
               end else begin
                  err_d = 1'b1;
               end
               x_d = (x_q == H) ? x_q : x_q + 1'b1;
            end
            if (hr_fall) begin
               if (ph_q || x_q != H) err_d = 1'b1;
               if (y_q < V) begin
                  y_d    = y_q + 1'b1;
                  base_d = base_q + H;
               end
               x_d  = '0;
               ph_d = 1'b0;
            end
            // line-end updates above feed the verdict when both edges coincide
            if (vs_rise) begin
               state_d = ARMED;
               done_d  = 1'b1;
               ok_d    = !err_d && y_d == V && !hr_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cam_pclk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         vs_q      <= 1'b0;
         hr_q      <= 1'b0;
         d_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         base_q    <= '0;
         ph_q      <= 1'b0;
         hi_q      <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         vs_q      <= cam_vsync;
         hr_q      <= cam_href;
         d_q       <= cam_data;
         x_q       <= x_d;
         y_q       <= y_d;
         base_q    <= base_d;
         ph_q      <= ph_d;
         hi_q      <= hi_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
      end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = state_q == ACTIVE;
   assign frame_done = done_q;
   assign frame_ok   = ok_q;
endmodule
